// File: rtl/expansion_timer.sv
// Programmable down-counting timer on an 8-bit I/O expansion bus; IRQ path gated by EXPANSION_TIMER_IRQ_EN.
// Latency: reads are combinational, writes commit on one clock, o_irq lags EXP by one clock.
// Backpressure: none, the bus is never stalled and a held write strobe commits only once.
module expansion_timer #(
   parameter logic [7:0] BASE_ADDR = 8'hF4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_bus,
   output logic [7:0] o_bus,
   output logic       o_busNOE,
   input  logic       i_ioNCE,
   input  logic [7:0] i_ioAddress,
   input  logic       i_ioNOE,
   input  logic       i_ioNWE,
   output logic       o_irq
);

   logic       sel;
   logic [1:0] reg_sel;
   logic       wr_now;
   logic       wr_prev;
   logic       wr_fire;
   logic       en;
   logic       auto_rl;
   logic       irqen;
   logic       exp_flag;
   logic [7:0] presc;
   logic [7:0] reload;
   logic [7:0] count;
   logic [7:0] pcnt;
   logic       tick;
   logic       expire;
   logic [7:0] rd_dat;

   assign sel     = ~i_ioNCE & (i_ioAddress[7:2] == BASE_ADDR[7:2]);
   assign reg_sel = i_ioAddress[1:0];
   assign wr_now  = sel & ~i_ioNWE;
   assign wr_fire = wr_now & ~wr_prev;
   assign tick    = en & (pcnt == presc);
   assign expire  = tick & (count == 8'd0);

   always_comb begin
      rd_dat = 8'h00;
      case (reg_sel)
         2'd0: rd_dat = {5'b0, irqen, auto_rl, en};
         2'd1: rd_dat = presc;
         2'd2: rd_dat = count;
         2'd3: rd_dat = {7'b0, exp_flag};
         default: rd_dat = 8'h00;
      endcase
   end

   assign o_busNOE = ~(sel & ~i_ioNOE);
   assign o_bus    = o_busNOE ? 8'hFF : rd_dat;

   // Later assignments in this block win, which encodes the collision precedence:
   // bus writes override tick effects, and expiry overrides a STATUS clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_prev  <= 1'b0;
         en       <= 1'b0;
         auto_rl  <= 1'b0;
         exp_flag <= 1'b0;
         presc    <= 8'd0;
         reload   <= 8'd0;
         count    <= 8'd0;
         pcnt     <= 8'd0;
      end else begin
         wr_prev <= wr_now;
         if (en) begin
            pcnt <= tick ? 8'd0 : pcnt + 8'd1;
         end
         if (tick) begin
            if (count != 8'd0) begin
               count <= count - 8'd1;
            end else if (auto_rl) begin
               count <= reload;
            end else begin
               en <= 1'b0;
            end
         end
         if (wr_fire) begin
            case (reg_sel)
               2'd0: begin
                  en      <= i_bus[0];
                  auto_rl <= i_bus[1];
               end
               2'd1: presc <= i_bus;
               2'd2: begin
                  reload <= i_bus;
                  count  <= i_bus;
                  pcnt   <= 8'd0;
               end
               2'd3: begin
                  if (i_bus[0]) begin
                     exp_flag <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
         if (expire) begin
            exp_flag <= 1'b1;
         end
      end
   end

`ifdef EXPANSION_TIMER_IRQ_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         irqen <= 1'b0;
         o_irq <= 1'b0;
      end else begin
         if (wr_fire && (reg_sel == 2'd0)) begin
            irqen <= i_bus[2];
         end
         o_irq <= exp_flag & irqen;
      end
   end
`else
   assign irqen = 1'b0;
   assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_expansion_timer.sv
// Scoreboard bench for expansion_timer: expectations are queued as stimulus is issued, then popped on each bus read.
module tb_expansion_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bus_in;
   logic [7:0] addr;
   logic       nce;
   logic       noe;
   logic       nwe;
   logic [7:0] bus_out;
   logic       busnoe;
   logic       irq;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   localparam logic [7:0] R_CTRL  = 8'hF4;
   localparam logic [7:0] R_PRESC = 8'hF5;
   localparam logic [7:0] R_CNT   = 8'hF6;
   localparam logic [7:0] R_STAT  = 8'hF7;
`ifdef EXPANSION_TIMER_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   always #5 clk = ~clk;

   expansion_timer #(.BASE_ADDR(8'hF4)) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_bus(bus_in),
      .o_bus(bus_out),
      .o_busNOE(busnoe),
      .i_ioNCE(nce),
      .i_ioAddress(addr),
      .i_ioNOE(noe),
      .i_ioNWE(nwe),
      .o_irq(irq)
   );

   // One idle clock, then one clock with the strobe low; returns 1 time unit after the commit edge.
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      nce = 1'b0; addr = a; bus_in = d; nwe = 1'b0;
      @(posedge clk); #1;
      nwe = 1'b1; nce = 1'b1;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic n);
      nce = 1'b0; addr = a; noe = 1'b0;
      #1;
      d = bus_out; n = busnoe;
      noe = 1'b1; nce = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d, want;
      logic n;
      rst = 1'b1; nce = 1'b1; noe = 1'b1; nwe = 1'b1; addr = 8'h00; bus_in = 8'h00;
      #12;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
      for (int i = 0; i < 4; i++) begin
         bus_read(R_CTRL + 8'(i), d, n);
         want = exp_q.pop_front();
         total++;
         if (d !== want || n !== 1'b0) begin
            bad++;
            $display("FAIL reset_reg%0d got=%h noe=%b want=%h noe=0", i, d, n, want);
         end
      end
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq got=%b want=0", irq);
      end
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   task automatic test_periodic();
      logic [7:0] d, want;
      logic n;
      int t;
      bus_write(R_PRESC, 8'd3);
      bus_write(R_CNT, 8'd2);
      bus_write(R_CTRL, 8'h03);
      for (int k = 1; k <= 26; k++) begin
         t = k / 4;
         exp_q.push_back((t % 3 == 0) ? 8'd2 : (t % 3 == 1) ? 8'd1 : 8'd0);
         exp_q.push_back((k >= 12) ? 8'h01 : 8'h00);
      end
      for (int k = 1; k <= 26; k++) begin
         @(posedge clk); #1;
         bus_read(R_CNT, d, n);
         want = exp_q.pop_front();
         total++;
         if (d !== want) begin
            bad++;
            $display("FAIL periodic_count clk=%0d got=%h want=%h", k, d, want);
         end
         bus_read(R_STAT, d, n);
         want = exp_q.pop_front();
         total++;
         if (d !== want) begin
            bad++;
            $display("FAIL periodic_exp clk=%0d got=%h want=%h", k, d, want);
         end
      end
      bus_write(R_CTRL, 8'h00);
      bus_write(R_STAT, 8'h01);
      exp_q.push_back(8'h00);
      bus_read(R_STAT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL status_clear got=%h want=%h", d, want);
      end
   endtask

   task automatic test_oneshot();
      logic [7:0] d, want;
      logic n;
      bus_write(R_PRESC, 8'd0);
      bus_write(R_CNT, 8'd1);
      bus_write(R_CTRL, 8'h01);
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(8'h00);
         exp_q.push_back((k >= 2) ? 8'h01 : 8'h00);
         exp_q.push_back((k >= 2) ? 8'h00 : 8'h01);
      end
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         for (int r = 0; r < 3; r++) begin
            bus_read((r == 0) ? R_CNT : (r == 1) ? R_STAT : R_CTRL, d, n);
            want = exp_q.pop_front();
            total++;
            if (d !== want) begin
               bad++;
               $display("FAIL oneshot_r%0d clk=%0d got=%h want=%h", r, k, d, want);
            end
         end
      end
      bus_write(R_STAT, 8'h01);
   endtask

   task automatic test_precedence();
      logic [7:0] d, want;
      logic n;
      bus_write(R_CNT, 8'd1);
      bus_write(R_CTRL, 8'h01);
      bus_write(R_CTRL, 8'h01);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h00);
      bus_read(R_CTRL, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL ctrl_beats_autoclear got=%h want=%h", d, want);
      end
      bus_read(R_STAT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL precedence_exp got=%h want=%h", d, want);
      end
      @(posedge clk); #1;
      bus_read(R_CTRL, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL autoclear_after got=%h want=%h", d, want);
      end
      bus_write(R_STAT, 8'h01);
   endtask

   task automatic test_irq();
      logic [7:0] d, want;
      logic n;
      bus_write(R_CNT, 8'd1);
      bus_write(R_CTRL, 8'h05);
      // per clock: EXP, o_irq
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back({7'b0, IRQ_BUILD});
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         bus_read(R_STAT, d, n);
         want = exp_q.pop_front();
         total++;
         if (d !== want) begin
            bad++;
            $display("FAIL irq_exp clk=%0d got=%h want=%h", k, d, want);
         end
         want = exp_q.pop_front();
         total++;
         if ({7'b0, irq} !== want) begin
            bad++;
            $display("FAIL irq_rise clk=%0d got=%b want=%h", k, irq, want);
         end
      end
      exp_q.push_back(IRQ_BUILD ? 8'h04 : 8'h00);
      bus_read(R_CTRL, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL irq_ctrl got=%h want=%h", d, want);
      end
      bus_write(R_STAT, 8'h01);
      exp_q.push_back(8'h00);
      exp_q.push_back({7'b0, IRQ_BUILD});
      exp_q.push_back(8'h00);
      bus_read(R_STAT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL irq_status_clear got=%h want=%h", d, want);
      end
      want = exp_q.pop_front();
      total++;
      if ({7'b0, irq} !== want) begin
         bad++;
         $display("FAIL irq_hold got=%b want=%h", irq, want);
      end
      @(posedge clk); #1;
      want = exp_q.pop_front();
      total++;
      if ({7'b0, irq} !== want) begin
         bad++;
         $display("FAIL irq_fall got=%b want=%h", irq, want);
      end
      bus_write(R_CTRL, 8'h07);
      exp_q.push_back(IRQ_BUILD ? 8'h07 : 8'h03);
      bus_read(R_CTRL, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL ctrl_bit2 got=%h want=%h", d, want);
      end
      bus_write(R_CTRL, 8'h00);
      bus_write(R_STAT, 8'h01);
   endtask

   task automatic test_clear_collision();
      logic [7:0] d, want;
      logic n;
      bus_write(R_CNT, 8'd0);
      bus_write(R_CTRL, 8'h03);
      bus_write(R_STAT, 8'h01);
      exp_q.push_back(8'h01);
      bus_read(R_STAT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL clear_vs_expiry got=%h want=%h", d, want);
      end
      bus_write(R_CTRL, 8'h00);
      bus_write(R_STAT, 8'h01);
      exp_q.push_back(8'h00);
      bus_read(R_STAT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL clear_idle got=%h want=%h", d, want);
      end
   endtask

   task automatic test_held_strobe();
      logic [7:0] d, want;
      logic n;
      bus_write(R_PRESC, 8'd1);
      bus_write(R_CNT, 8'h40);
      bus_write(R_CTRL, 8'h03);
      @(posedge clk); #1;
      nce = 1'b0; addr = R_CNT; bus_in = 8'h10; nwe = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      nwe = 1'b1; nce = 1'b1;
      exp_q.push_back(8'h0E);
      exp_q.push_back(8'h0D);
      bus_read(R_CNT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL held_strobe_load got=%h want=%h", d, want);
      end
      repeat (2) @(posedge clk);
      #1;
      bus_read(R_CNT, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL held_strobe_decr got=%h want=%h", d, want);
      end
      bus_write(R_CTRL, 8'h00);
   endtask

   task automatic test_window();
      logic [7:0] d, want;
      logic n;
      logic [7:0] outside[3];
      outside[0] = 8'hF8; outside[1] = 8'hF3; outside[2] = 8'h00;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
      for (int i = 0; i < 3; i++) begin
         bus_read(outside[i], d, n);
         want = exp_q.pop_front();
         total++;
         if (d !== want || n !== 1'b1) begin
            bad++;
            $display("FAIL window_addr_%h got=%h noe=%b want=%h noe=1", outside[i], d, n, want);
         end
      end
      nce = 1'b1; addr = R_PRESC; noe = 1'b0;
      #1;
      want = exp_q.pop_front();
      total++;
      if (bus_out !== want || busnoe !== 1'b1) begin
         bad++;
         $display("FAIL window_nce got=%h noe=%b want=%h noe=1", bus_out, busnoe, want);
      end
      noe = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d, want;
      logic n;
      bus_write(R_PRESC, 8'd0);
      bus_write(R_CNT, 8'h20);
      bus_write(R_CTRL, 8'h03);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
      for (int i = 0; i < 4; i++) begin
         bus_read(R_CTRL + 8'(i), d, n);
         want = exp_q.pop_front();
         total++;
         if (d !== want) begin
            bad++;
            $display("FAIL midreset_reg%0d got=%h want=%h", i, d, want);
         end
      end
      nce = 1'b0; addr = R_PRESC; bus_in = 8'h5A; nwe = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      bus_in = 8'h33;
      repeat (2) @(posedge clk);
      #1;
      nwe = 1'b1; nce = 1'b1;
      exp_q.push_back(8'h5A);
      bus_read(R_PRESC, d, n);
      want = exp_q.pop_front();
      total++;
      if (d !== want) begin
         bad++;
         $display("FAIL strobe_through_reset got=%h want=%h", d, want);
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_precedence();
      test_irq();
      test_clear_collision();
      test_held_strobe();
      test_window();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/expansion_timer.md
EXPANSION_TIMER -- requirements
Module: expansion_timer

Interface
REQ-001 Parameter: BASE_ADDR, default 8'hF4, I/O address of register 0; bits [1:0] SHALL be ignored, so the block occupies BASE_ADDR[7:2],2'b00 to BASE_ADDR[7:2],2'b11.
REQ-002 Port: i_clk  in  1  design clock; the expansion strobes are synchronous to it.
REQ-003 Port: i_reset  in  1  reset, asynchronous, active-high.
REQ-004 Port: i_bus  in  8  write data from the CPU bus.
REQ-005 Port: o_bus  out  8  read data towards the CPU bus.
REQ-006 Port: o_busNOE  out  1  active-low read-data enable.
REQ-007 Port: i_ioNCE  in  1  active-low expansion chip enable.
REQ-008 Port: i_ioAddress  in  8  expansion register address.
REQ-009 Port: i_ioNOE  in  1  active-low read strobe.
REQ-010 Port: i_ioNWE  in  1  active-low write strobe.
REQ-011 Port: o_irq  out  1  registered, active-high timer interrupt.

Function
REQ-012 sel = ~i_ioNCE & (i_ioAddress[7:2] == BASE_ADDR[7:2]); reg = i_ioAddress[1:0].
REQ-013 Register map:
- 0 CTRL: bit0 EN, bit1 AUTO, bit2 IRQEN, other bits read 0.
- 1 PRESC: 8 bits, read/write.
- 2 write RELOAD (8 bits); read live COUNT.
- 3 STATUS: bit0 EXP; writing 1 to bit0 clears EXP; other bits read 0.
REQ-014 Read path is combinational: o_busNOE = ~(sel & ~i_ioNOE); o_bus = selected register while o_busNOE=0, else 8'hFF.
REQ-015 Write commits on exactly one clock: the first rising i_clk at which sel & ~i_ioNWE is true after being false on the previous clock (edge detect on a registered copy); a held strobe SHALL NOT write again.
REQ-016 A write to reg 2 SHALL load both RELOAD and COUNT from i_bus and clear the prescaler counter PCNT, in the same clock.
REQ-017 Prescaler: while EN=1, PCNT increments each clock; when PCNT==PRESC, PCNT<=0 and a one-clock tick is generated. One tick occurs every PRESC+1 clocks, so PRESC=0 gives a tick every clock. While EN=0, PCNT and COUNT hold.
REQ-018 On a tick with COUNT!=0: COUNT<=COUNT-1.
REQ-019 On a tick with COUNT==0:
- EXP<=1.
- If AUTO=1: COUNT<=RELOAD.
- If AUTO=0: EN<=0 and COUNT stays 0.
REQ-020 The period is (RELOAD+1)*(PRESC+1) clocks; RELOAD=0 with AUTO=1 sets EXP every PRESC+1 clocks.
REQ-021 Precedence when events coincide in one clock:
- A reg-2 write beats a tick decrement or reload.
- EXP set by expiry beats an EXP clear by a STATUS write.
- A CTRL write of EN beats the automatic EN clear.
REQ-022 o_irq <= EXP & IRQEN, registered with 1 clock latency.

Reset
REQ-023 While i_reset=1: CTRL, PRESC, RELOAD, COUNT, PCNT, EXP, o_irq and the strobe edge register are all 0, independent of i_clk.
REQ-024 Reset values of the outputs: o_busNOE follows REQ-014 combinationally during reset; o_bus=8'hFF whenever o_busNOE=1.
REQ-025 A reset asserted mid-count or mid-strobe SHALL abort the operation. A strobe already low when reset releases SHALL write once, on the first clock after release.

Configuration
REQ-026 Macro EXPANSION_TIMER_IRQ_EN:
- Defined: IRQEN and o_irq behave as specified above.
- Undefined: CTRL bit2 is not implemented and reads 0, and o_irq is constant 0.
- EXP behaves identically in both builds.

Verification
REQ-027 Write PRESC=3, RELOAD=2, CTRL=0x03 -> COUNT reads 2,1,0 at 4-clock intervals; EXP=1 at clock 12 after the CTRL write; COUNT reloads to 2; the sequence repeats with period 12.
REQ-028 AUTO=0, RELOAD=1, PRESC=0, EN=1 -> EXP=1 after 2 ticks; CTRL reads 0x00; COUNT holds 0.
REQ-029 IRQEN=1 and expiry -> o_irq rises 1 clock after EXP. STATUS write 0x01 -> EXP=0, and o_irq falls 1 clock later. Build without the macro -> o_irq stays 0 and CTRL reads 0x03 after writing 0x07.
REQ-030 Hold i_ioNWE low for 5 clocks on reg 2 with i_bus=0x10 while running -> exactly one load; COUNT decrements from 0x10 afterwards.
REQ-031 STATUS clear issued in the same clock as an expiry -> EXP reads 1.
REQ-032 Read with address outside the window -> o_busNOE=1, o_bus=8'hFF. Assert i_reset mid-count -> all registers read 0 immediately.
